pix_capture_writer: RTL
=======================

Name: pix_capture_writer

Overview:
- Software-armed snapshot writer that fills the 1024x32 pixel capture BRAM through its port A (clk domain).
- Sits directly upstream of the capture RAM block, between the channelised pixel stream (phase/IQ words tagged with a channel index) and port A.
- Selects one channel, or all channels, with optional frame-sync alignment and decimation.
- Writes a programmable number of words from address 0 upward, then reports done and the word count to software registers.

Parameters:
- ADDR_W, 10, BRAM address width; depth = 2^ADDR_W.
- DATA_W, 32, sample and BRAM data width.
- CH_W, 8, channel index width.
- DEC_W, 8, decimation field width.

Ports:
- clk  in  1  fabric clock; also drives BRAM port A.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  stream sample valid.
- in_data  in  DATA_W  stream sample.
- in_ch  in  CH_W  channel index of in_data.
- in_sync  in  1  frame start; meaningful only when in_valid=1.
- ctrl_start  in  1  software level; rising edge arms, low aborts.
- ctrl_ch_sel  in  CH_W  channel to capture.
- ctrl_ch_all  in  1  1 = capture every channel.
- ctrl_wait_sync  in  1  1 = start at first in_sync.
- ctrl_decim  in  DEC_W  keep 1 of every (ctrl_decim+1) qualifying samples.
- ctrl_num_words  in  ADDR_W+1  words to capture; 0 or >2^ADDR_W means 2^ADDR_W.
- bram_we  out  1  port A write enable.
- bram_en_a  out  1  port A enable; equals bram_we.
- bram_addr  out  ADDR_W  port A address.
- bram_wr_data  out  DATA_W  port A write data.
- stat_busy  out  1  high in ARMED or CAPTURE.
- stat_done  out  1  capture complete.
- stat_count  out  ADDR_W+1  words written in the current or last capture.

Behaviour:
- Reset: all outputs 0; state IDLE; decimation counter 0; start edge detector cleared, so a start level held high through reset does not arm.
- start_edge = ctrl_start & ~ctrl_start_d (registered).
- On start_edge the block latches ctrl_ch_sel, ctrl_ch_all, ctrl_wait_sync, ctrl_decim and the clamped ctrl_num_words as N.
- On start_edge the block clears stat_count, stat_done and the decimation counter.
- The input sample present on the start_edge cycle is never eligible.
- IDLE: if start_edge, go to ARMED when wait_sync=1, else to CAPTURE.
- ARMED: stay until in_valid & in_sync & channel match, then go to CAPTURE.
  - That sync sample is the first eligible sample.
  - It is processed in the same cycle as the ARMED->CAPTURE transition.
- CAPTURE: a sample qualifies when in_valid=1 and (ch_all=1 or in_ch==ch_sel).
  - A qualifying sample is kept when dec_cnt==0.
  - dec_cnt advances on every qualifying sample and wraps to 0 after reaching the latched decim value.
  - decim=0 keeps every qualifying sample.
- Write latency is 1 cycle. A sample kept in cycle t produces, in cycle t+1:
  - bram_we=1 and bram_en_a=1;
  - bram_wr_data = that sample;
  - bram_addr = stat_count[ADDR_W-1:0] as it was before the write;
  - stat_count incremented.
- When the write that makes stat_count==N is issued, go to DONE.
  - No further writes are issued.
  - stat_done=1 and stat_busy=0 in the cycle after that write.
- DONE: hold stat_done and stat_count. A start_edge re-arms exactly as from IDLE, clearing stat_done.
- Abort: ctrl_start=0 while in ARMED or CAPTURE returns to IDLE next cycle.
  - stat_done stays 0 and stat_count holds.
  - A write already in the output register still completes.
- Address never wraps: the maximum N equals the depth, so the final address is 2^ADDR_W-1.
- bram_we/bram_en_a are 0 in every cycle with no kept sample and in IDLE/DONE.
- bram_addr and bram_wr_data hold their last values when not writing.
- rst during CAPTURE: no write is issued in any cycle where rst is sampled high or afterwards; all outputs return to reset values.
- The block never reads the BRAM. Software reads via port B only when stat_done=1.

Test Plan:
- No sync, all channels, decim=0, N=4: raise start, then drive valid data 0xA0..0xA5 on consecutive cycles -> writes 0xA0..0xA3 to addresses 0..3 on cycles 1..4 after the data; stat_done=1 and stat_count=4; 0xA4/0xA5 not written.
- ch_sel=5, decim=2, N=3: stream channels 0..7 repeating, data = {cycle count} -> writes only the ch5 samples numbered 0, 3 and 6 among ch5 samples, to addresses 0..2.
- wait_sync=1, ch_sel=2: the sync pulse arrives with in_ch=2 at cycle 20 -> stat_busy=1 from arm; first write at cycle 21 to address 0 with the cycle-20 data; no writes before it.
- ctrl_num_words=0: full stream -> exactly 1024 writes, last to address 1023; stat_count=1024; stat_done set; no 1025th write.
- Abort and reset: drop ctrl_start after 10 writes -> IDLE, stat_count=10, stat_done=0. Re-arm, then assert rst mid-capture -> bram_we=0 from the rst cycle and all status outputs 0.

Source files
------------

// File: rtl/pix_capture_writer_if.sv
// pix_capture_writer_if: channelised pixel stream in, BRAM port A write bus out.
// master = stream source / RAM side, slave = the capture writer.
interface pix_capture_writer_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int CH_W   = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic [CH_W-1:0]   in_ch;
   logic              in_sync;
   logic              bram_we;
   logic              bram_en_a;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_wr_data;
   modport master (output in_valid, in_data, in_ch, in_sync,
                   input  bram_we, bram_en_a, bram_addr, bram_wr_data);
   modport slave  (input  in_valid, in_data, in_ch, in_sync,
                   output bram_we, bram_en_a, bram_addr, bram_wr_data);
endinterface

// File: rtl/pix_capture_writer.sv
// pix_capture_writer: software-armed snapshot of one/all stream channels into BRAM port A.
// Optional frame-sync alignment and decimation; writes N words from address 0, then reports done.
module pix_capture_writer #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int CH_W   = 8,
   parameter int DEC_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   pix_capture_writer_if.slave   bus,
   input  logic                  ctrl_start,
   input  logic [CH_W-1:0]       ctrl_ch_sel,
   input  logic                  ctrl_ch_all,
   input  logic                  ctrl_wait_sync,
   input  logic [DEC_W-1:0]      ctrl_decim,
   input  logic [ADDR_W:0]       ctrl_num_words,
   output logic                  stat_busy,
   output logic                  stat_done,
   output logic [ADDR_W:0]       stat_count
);
   localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3;
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   logic [1:0]        state;
   logic              start_d, ch_all, wait_sync, done, we_r;
   logic [CH_W-1:0]   ch_sel;
   logic [DEC_W-1:0]  decim, dec_cnt;
   logic [ADDR_W:0]   n, count, num_clamp;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] data_r;
   logic              start_edge, active, eligible, keep;
   always_comb begin
      start_edge = ctrl_start & ~start_d;
      active     = (state == ARMED) || (state == CAPTURE);
      num_clamp  = (ctrl_num_words == '0 || ctrl_num_words > DEPTH) ? DEPTH : ctrl_num_words;
      // The sync sample that releases ARMED is itself the first eligible sample.
      eligible   = ctrl_start & bus.in_valid & (ch_all | (bus.in_ch == ch_sel))
                   & ((state == CAPTURE) | ((state == ARMED) & bus.in_sync));
      keep       = eligible & (dec_cnt == '0) & (count != n);
   end
   always_ff @(posedge clk) begin
      // Tracks the level even in reset so a start held high through reset never arms.
      start_d <= ctrl_start;
      if (rst) begin
         state     <= IDLE;
         ch_sel    <= '0;
         ch_all    <= 1'b0;
         wait_sync <= 1'b0;
         decim     <= '0;
         dec_cnt   <= '0;
         n         <= '0;
         count     <= '0;
         done      <= 1'b0;
         we_r      <= 1'b0;
         addr_r    <= '0;
         data_r    <= '0;
      end else begin
         we_r  <= keep;
         count <= count + {{ADDR_W{1'b0}}, keep};
         if (keep) begin
            addr_r <= count[ADDR_W-1:0];
            data_r <= bus.in_data;
         end
         if (eligible)
            dec_cnt <= (dec_cnt == decim) ? '0 : dec_cnt + 1'b1;
         if (start_edge) begin
            ch_sel    <= ctrl_ch_sel;
            ch_all    <= ctrl_ch_all;
            wait_sync <= ctrl_wait_sync;
            decim     <= ctrl_decim;
            n         <= num_clamp;
            count     <= '0;
            done      <= 1'b0;
            dec_cnt   <= '0;
            state     <= ctrl_wait_sync ? ARMED : CAPTURE;
         end else if (active && !ctrl_start) begin
            state <= IDLE;
         end else if (state == ARMED && eligible) begin
            state <= CAPTURE;
         end else if (state == CAPTURE && count == n) begin
            state <= DONE;
            done  <= 1'b1;
         end
      end
   end
   // Write strobe is masked by rst so nothing reaches the RAM in a reset cycle.
   assign bus.bram_we      = we_r & ~rst;
   assign bus.bram_en_a    = we_r & ~rst;
   assign bus.bram_addr    = addr_r;
   assign bus.bram_wr_data = data_r;
   assign stat_busy        = active;
   assign stat_done        = done;
   assign stat_count       = count;
   logic unused_ok;
   assign unused_ok = wait_sync;
endmodule
